// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and default widths.
// Used by both the transmit and receive paths.
package uart_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..prescale-1 while run is high and pulses
// bit_done on the last cycle of each bit. A prescale of 0 behaves as 1.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);
  logic [PRESCALE_WIDTH-1:0] count;
  logic [PRESCALE_WIDTH-1:0] last;

  assign last     = (prescale == '0) ? '0 : prescale - 1'b1;
  assign bit_done = run && (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  count <= '0;
    else if (!run || bit_done) count <= '0;
    else                      count <= count + 1'b1;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// stop bit; each bit held for Prescale clocks. TX_OUT and busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e               state;
  logic [DATA_WIDTH-1:0]     shift;
  logic                      par_bit;
  logic                      par_en_q;
  logic [PRESCALE_WIDTH-1:0] prs_q;
  logic [BW-1:0]             bit_cnt;
  logic                      bit_done;

  uart_tx_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .prescale (prs_q),
    .bit_done (bit_done)
  );

  // TX_OUT is loaded with the next bit's value on the edge that ends the current bit,
  // so the line changes exactly on bit boundaries with no output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      TX_OUT   <= STOP_BIT;
      busy     <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      prs_q    <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (Data_Valid) begin
          shift    <= P_DATA;
          par_bit  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
          par_en_q <= PAR_EN;
          prs_q    <= Prescale;
          bit_cnt  <= '0;
          TX_OUT   <= START_BIT;
          busy     <= 1'b1;
          state    <= START;
        end
        START: if (bit_done) begin
          TX_OUT <= shift[0];
          state  <= DATA;
        end
        DATA: if (bit_done) begin
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              TX_OUT <= par_bit;
              state  <= PARITY;
            end else begin
              TX_OUT <= STOP_BIT;
              state  <= STOP;
            end
          end else begin
            shift   <= shift >> 1;
            TX_OUT  <= shift[1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: if (bit_done) begin
          TX_OUT <= STOP_BIT;
          state  <= STOP;
        end
        STOP: if (bit_done) begin
          TX_OUT <= STOP_BIT;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= STOP_BIT;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames from the test plan plus random frames,
// each compared cycle by cycle against a frame built from the bit-sequence rules.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller set the request at a negedge; acceptance happens on the following posedge.
  // Checks every cycle of the frame plus the first idle cycle after busy falls.
  task automatic run_frame(input string name, input logic [7:0] d, input bit pe, input bit pt,
                           input logic [5:0] ps, input bit hold, input bit inject,
                           input logic [7:0] next_d);
    logic bits [0:10];
    int   nb, p, len;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
    if (pe) bits[nb++] = 1'(($countones(d) % 2)) ^ pt;
    bits[nb++] = 1'b1;
    p   = (ps == 0) ? 1 : int'(ps);
    len = nb * p;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) Data_Valid = 1'b0;
      if (k < len) begin
        chk($sformatf("%s.tx[%0d]", name, k), TX_OUT, bits[k / p]);
        chk($sformatf("%s.busy[%0d]", name, k), busy, 1'b1);
      end else begin
        chk($sformatf("%s.idle_tx", name), TX_OUT, 1'b1);
        chk($sformatf("%s.idle_busy", name), busy, 1'b0);
        if (hold) P_DATA = next_d;
      end
      if (inject && k == len / 2) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h3C;
        Prescale   = 6'($urandom_range(0, 63));
        PAR_TYP    = ~pt;
        PAR_EN     = ~pe;
      end
      if (inject && k == len / 2 + 1) Data_Valid = 1'b0;
    end
  endtask

  task automatic start(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps);
    @(negedge clk);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    #3;
    chk("reset.tx", TX_OUT, 1'b1);
    chk("reset.busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    start(8'hA5, 1, 0, 6'd8);  run_frame("even_a5", 8'hA5, 1, 0, 6'd8, 0, 0, 8'h00);
    start(8'h01, 1, 1, 6'd4);  run_frame("odd_01", 8'h01, 1, 1, 6'd4, 0, 0, 8'h00);
    start(8'h00, 1, 1, 6'd4);  run_frame("odd_00", 8'h00, 1, 1, 6'd4, 0, 0, 8'h00);
    start(8'hFF, 0, 0, 6'd1);  run_frame("np_p1", 8'hFF, 0, 0, 6'd1, 0, 0, 8'h00);
    start(8'hFF, 0, 0, 6'd0);  run_frame("np_p0", 8'hFF, 0, 0, 6'd0, 0, 0, 8'h00);

    start(8'hC3, 1, 0, 6'd8);  run_frame("ignore_c3", 8'hC3, 1, 0, 6'd8, 0, 1, 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("ignore.post_tx[%0d]", k), TX_OUT, 1'b1);
      chk($sformatf("ignore.post_busy[%0d]", k), busy, 1'b0);
    end

    start(8'h55, 0, 0, 6'd16); run_frame("b2b_55", 8'h55, 0, 0, 6'd16, 1, 0, 8'hAA);
    run_frame("b2b_aa", 8'hAA, 0, 0, 6'd16, 0, 0, 8'h00);

    // Reset asserted between edges during the third data bit (frame bit index 3).
    start(8'h5A, 0, 0, 6'd8);
    repeat (3 * 8 + 3) @(negedge clk);
    Data_Valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.tx", TX_OUT, 1'b1);
    chk("midrst.busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start(8'h81, 1, 0, 6'd8);  run_frame("after_rst_81", 8'h81, 1, 0, 6'd8, 0, 0, 8'h00);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      logic [5:0] ps;
      bit pe, pt;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ps = 6'd8;
        1: ps = 6'd16;
        2: ps = 6'd32;
        default: ps = 6'($urandom_range(0, 12));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start(d, pe, pt, ps);
      run_frame($sformatf("rand%0d", r), d, pe, pt, ps, 0, 0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
